// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl -- initiator-side controller for one port of a synchronous RAM
// with a one-cycle registered read.
//
// Requests arrive on a valid/ready handshake and are turned into registered
// RAM port signals. Read data comes back from the RAM two edges after the
// request is accepted. It is collected in an in-order response FIFO that
// the consumer drains with backpressure. A bulk-init sequencer writes
// INIT_VAL to every address, one word per cycle.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   req_valid_i/ready_o request handshake; req_we_i, req_addr_i, req_wdata_i
//   rsp_valid_o/ready_i response handshake; rsp_data_o is the FIFO head
//   init_start_i       request a full-memory init (ignored while busy)
//   init_busy_o        init in progress; init_done_o one-cycle completion pulse
//   mem_we_o, mem_addr_o, mem_wdata_o  registered RAM port drive
//   mem_rdata_i        RAM registered read data

module ram_port_ctrl #(
    parameter int unsigned DATA      = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR      = $clog2(DEPTH),
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned INIT_VAL  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [ADDR-1:0] req_addr_i,
    input  logic [DATA-1:0] req_wdata_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DATA-1:0] rsp_data_o,
    input  logic            init_start_i,
    output logic            init_busy_o,
    output logic            init_done_o,
    output logic            mem_we_o,
    output logic [ADDR-1:0] mem_addr_o,
    output logic [DATA-1:0] mem_wdata_o,
    input  logic [DATA-1:0] mem_rdata_i
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);
    localparam logic [DATA-1:0] INIT_WORD = DATA'(INIT_VAL);

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [ADDR-1:0] addr_q, addr_d;   // doubles as the init counter
    logic [DATA-1:0] wdata_q, wdata_d;
    logic            done_q, done_d;

    // Read tag pipeline: stage 1 = address on the RAM port, stage 2 = data on mem_rdata_i.
    logic            rd1_q, rd2_q;

    logic [DATA-1:0]  buf_q [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W:0]   outstanding;
    logic             accept, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Reads in flight reserve their FIFO slot at accept time, so the FIFO can
    // never overflow. A pop only frees a slot from the following cycle.
    assign outstanding = (CNT_W+1)'(count_q) + (CNT_W+1)'(rd1_q) + (CNT_W+1)'(rd2_q);
    assign req_ready_o = !rst && (state_q == IDLE) && !init_start_i
                         && (outstanding < (CNT_W+1)'(RSP_DEPTH));
    assign accept      = req_valid_i && req_ready_o;
    assign push        = rd2_q;
    assign rsp_valid_o = (count_q != '0);
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign rsp_data_o  = buf_q[rd_ptr_q];

    assign init_busy_o = (state_q == INIT);
    assign init_done_o = done_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_start_i) begin
                    state_d = INIT;
                    we_d    = 1'b1;
                    addr_d  = '0;
                    wdata_d = INIT_WORD;
                end else if (accept) begin
                    we_d   = req_we_i;
                    addr_d = req_addr_i;
                    if (req_we_i) begin
                        wdata_d = req_wdata_i;
                    end
                end
            end
            INIT: begin
                // The word at addr_q is written on this edge; stop after the last one.
                if (addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + ADDR'(1);
                end
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            rd1_q    <= 1'b0;
            rd2_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            rd1_q    <= accept && !req_we_i;
            rd2_q    <= rd1_q;
            count_q  <= count_d;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides which entries are
    // valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Self-checking bench for ram_port_ctrl. A simple RAM sits on the memory
// port. A transaction-level model predicts every output on every cycle.
// Directed scenarios add literal expectations, and a randomized phase
// follows them.

module tb_ram_port_ctrl;

    localparam int DATA      = 4;
    localparam int DEPTH     = 16;
    localparam int ADDR      = 4;
    localparam int RSP_DEPTH = 4;
    localparam int INIT_VAL  = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ram_clr = 1'b1;
    logic            req_valid = 1'b0, req_we = 1'b0;
    logic [ADDR-1:0] req_addr = '0;
    logic [DATA-1:0] req_wdata = '0;
    logic            req_ready, rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [DATA-1:0] rsp_data;
    logic            init_start = 1'b0;
    logic            init_busy, init_done, mem_we;
    logic [ADDR-1:0] mem_addr;
    logic [DATA-1:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    ram_port_ctrl #(
        .DATA(DATA), .DEPTH(DEPTH), .RSP_DEPTH(RSP_DEPTH), .INIT_VAL(INIT_VAL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .init_start_i(init_start), .init_busy_o(init_busy), .init_done_o(init_done),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle registered read; no reset, so it keeps contents across rst.
    logic [DATA-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [DATA-1:0] d;
        int              rdy;   // cycle number from which the response is visible
    } rsp_t;

    logic [DATA-1:0] model_mem [DEPTH];
    rsp_t            mq [$];
    int              cyc   = 0;
    int              m_rem = 0;       // init words still to be written
    logic            m_we = 1'b0, m_done = 1'b0;
    logic [ADDR-1:0] m_addr = '0;
    logic [DATA-1:0] m_wdata = '0;

    initial for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    function automatic logic m_ready();
        return !rst && (m_rem == 0) && !init_start && (mq.size() < RSP_DEPTH);
    endfunction

    function automatic logic m_rsp_valid();
        return (mq.size() > 0) && (mq[0].rdy <= cyc);
    endfunction

    always @(posedge clk) begin
        logic acc, pop;
        // Whatever the port shows before this edge is written into the RAM now.
        if (m_we) model_mem[m_addr] = m_wdata;
        if (rst) begin
            mq.delete();
            m_rem = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_done = 1'b0;
        end else begin
            acc = req_valid && m_ready();
            pop = m_rsp_valid() && rsp_ready;
            if (pop) void'(mq.pop_front());
            m_done = 1'b0;
            if (m_rem != 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_we = 1'b0; m_done = 1'b1;
                end else begin
                    m_addr = m_addr + 1'b1;
                end
            end else if (init_start) begin
                m_rem = DEPTH; m_we = 1'b1; m_addr = '0; m_wdata = DATA'(INIT_VAL);
            end else if (acc) begin
                m_we = req_we; m_addr = req_addr;
                if (req_we) m_wdata = req_wdata;
                else mq.push_back('{d: model_mem[req_addr], rdy: cyc + 3});
            end else begin
                m_we = 1'b0;
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic issue(input logic we, input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
        int i;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        check("issue_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    logic [DATA-1:0] got [$];
    int busy_cnt = 0, done_cnt = 0, rdy_in_init = 0, init_idx = 0, init_addr_err = 0;

    task automatic read_expect(input string name, input logic [ADDR-1:0] a, input logic [DATA-1:0] e);
        int g0;
        g0 = got.size();
        rsp_ready = 1'b1;
        issue(1'b0, a, '0);
        ticks(3);
        check({name, "_cnt"}, got.size() - g0, 1);
        if (got.size() > g0) check(name, got[g0], e);
    endtask

    initial begin
        int acc_cnt, b0, d0, r0, e0, g0;
        logic [DATA-1:0] ev;

        fork
            forever begin
                @(negedge clk);
                check("req_ready", req_ready, m_ready());
                if (!rst) begin
                    check("rsp_valid", rsp_valid, m_rsp_valid());
                    if (m_rsp_valid()) check("rsp_data", rsp_data, mq[0].d);
                    check("init_busy", init_busy, m_rem != 0);
                    check("init_done", init_done, m_done);
                    check("mem_we", mem_we, m_we);
                    check("mem_addr", mem_addr, m_addr);
                    check("mem_wdata", mem_wdata, m_wdata);
                    if (rsp_valid && rsp_ready) got.push_back(rsp_data);
                    if (init_done) done_cnt++;
                    if (init_busy) begin
                        busy_cnt++;
                        if (req_ready) rdy_in_init++;
                        if (!mem_we || mem_addr != ADDR'(init_idx)) init_addr_err++;
                        init_idx++;
                    end else begin
                        init_idx = 0;
                    end
                end
            end
        join_none

        // Reset
        tick();
        ram_clr = 1'b0;
        ticks(2);
        check("rst_req_ready", req_ready, 0);
        rst = 1'b0;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_init_busy", init_busy, 0);
        check("rst_mem_we", mem_we, 0);

        // Write 0xA to addr 3, read it back on the next edge
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 4'hA;
        tick();
        check("wr_we_hi", mem_we, 1);
        req_we = 1'b0;
        tick();
        check("wr_we_lo", mem_we, 0);
        req_valid = 1'b0;
        tick();
        check("raw_lat_early", rsp_valid, 0);
        tick();
        check("raw_valid", rsp_valid, 1);
        check("raw_data", rsp_data, 4'hA);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Backpressure: six reads, only four fit
        for (int i = 0; i < 6; i++) issue(1'b1, ADDR'(i), DATA'(i + 1));
        acc_cnt = 0;
        g0 = got.size();
        for (int c = 0; c < 10; c++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR'(acc_cnt);
            @(negedge clk);
            if (req_ready) acc_cnt++;
            @(posedge clk); #1;
        end
        check("bp_accepted", acc_cnt, 4);
        check("bp_ready_lo", req_ready, 0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check("bp_ready_before_pop", req_ready, 0);
        tick();
        check("bp_ready_after_pop", req_ready, 1);
        ticks(5);
        rsp_ready = 1'b0;
        check("bp_rsp_cnt", got.size() - g0, 4);
        for (int i = 0; i < 4; i++)
            if (got.size() > g0 + i) check("bp_rsp_data", got[g0 + i], i + 1);

        // Full init
        b0 = busy_cnt; d0 = done_cnt; e0 = init_addr_err;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        ticks(DEPTH + 3);
        check("init_busy_cycles", busy_cnt - b0, 16);
        check("init_done_pulses", done_cnt - d0, 1);
        check("init_addr_seq", init_addr_err - e0, 0);
        read_expect("init_rd0", 4'd0, 4'h5);
        read_expect("init_rd7", 4'd7, 4'h5);
        read_expect("init_rd15", 4'd15, 4'h5);

        // Init while two reads are in flight
        issue(1'b1, 4'd8, 4'hC);
        issue(1'b1, 4'd9, 4'h3);
        rsp_ready = 1'b1;
        g0 = got.size(); d0 = done_cnt; r0 = rdy_in_init;
        issue(1'b0, 4'd8, '0);
        issue(1'b0, 4'd9, '0);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        ticks(DEPTH + 3);
        check("inflight_cnt", got.size() - g0, 2);
        if (got.size() > g0 + 1) begin
            check("inflight_d0", got[g0], 4'hC);
            check("inflight_d1", got[g0 + 1], 4'h3);
        end
        check("inflight_ready_in_init", rdy_in_init - r0, 0);
        check("inflight_done", done_cnt - d0, 1);

        // Reset in the middle of init: addrs 0-7 written, 8-15 untouched
        for (int i = 0; i < DEPTH; i++) issue(1'b1, ADDR'(i), (i < 8) ? 4'h9 : DATA'(i));
        d0 = done_cnt;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        ticks(7);
        check("rmi_addr7", mem_addr, 7);
        rst = 1'b1;
        tick();
        check("rmi_busy_lo", init_busy, 0);
        rst = 1'b0;
        ticks(DEPTH + 3);
        check("rmi_no_done", done_cnt - d0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            ev = (i < 8) ? 4'h5 : DATA'(i);
            read_expect("rmi_rd", ADDR'(i), ev);
        end

        // Reset with reads outstanding: nothing comes out afterwards
        rsp_ready = 1'b0;
        issue(1'b0, 4'd1, '0);
        issue(1'b0, 4'd2, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        g0 = got.size();
        rsp_ready = 1'b1;
        ticks(6);
        check("rst_flush_cnt", got.size() - g0, 0);
        check("rst_flush_valid", rsp_valid, 0);

        // Full buffer with simultaneous push and pop
        for (int i = 0; i < 4; i++) issue(1'b1, ADDR'(i), DATA'(i + 1));
        rsp_ready = 1'b0;
        g0 = got.size();
        for (int i = 0; i < 3; i++) issue(1'b0, ADDR'(i), '0);
        ticks(2);
        issue(1'b0, 4'd3, '0);
        rsp_ready = 1'b1;
        check("fb_ready_lo", req_ready, 0);
        ticks(6);
        check("fb_cnt", got.size() - g0, 4);
        for (int i = 0; i < 4; i++)
            if (got.size() > g0 + i) check("fb_data", got[g0 + i], i + 1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            req_valid  = ($urandom_range(0, 2) != 0);
            req_we     = $urandom_range(0, 1);
            req_addr   = ADDR'($urandom_range(0, DEPTH - 1));
            req_wdata  = DATA'($urandom);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            init_start = ($urandom_range(0, 99) == 0);
            rst        = ($urandom_range(0, 499) == 0);
            tick();
        end
        req_valid = 1'b0; init_start = 1'b0; rst = 1'b0; rsp_ready = 1'b1;
        ticks(DEPTH + 10);
        check("drain_empty", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
